// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage holds imem_addr_o stable from request until ack or redirect;
// memory samples the address only in the cycle it raises imem_ack_i.
interface fetch_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i
  );
endinterface : fetch_stage_if

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, fetches over a req/ack bus, and presents the fetched word to
// decode. A load-use stall that coincides with an ack parks the word in a
// one-entry skid buffer (state S_HOLD) so nothing is lost; a taken branch
// flushes IF/ID and the skid and restarts fetch at the target.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic                branch_taken_i,
  input  logic [31:0]         branch_target_i,
  fetch_stage_if.master       imem,
  output logic [31:0]         instr_o,
  output logic [5:0]          opcode_o,
  output logic [31:0]         pc_plus4_o,
  output logic                valid_o
);

  // S_REQ: request outstanding. S_HOLD: a word sits in the skid, no request.
  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc_plus4;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_pc;
  logic        w_imem_req;
  logic        w_capture;  // acked word goes straight into IF/ID
  logic        w_park;     // acked word goes into the skid (decode stalled)
  logic        w_bubble;   // no word this cycle, decode free: insert NOP
  logic        w_unpark;   // skid word moves into IF/ID

  // Sequential PC increment; 32-bit add wraps naturally at the top of memory.
  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_branch_pc = {branch_target_i[31:2], 2'b00};

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: a redirect always returns to S_REQ; otherwise a stalled
  // ack parks, and releasing the stall drains the skid.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no
    // latch is inferred.
    w_next_state = r_state;
    if (branch_taken_i) begin
      w_next_state = S_REQ;
    end else begin
      unique case (r_state)
        S_REQ:   if (imem.imem_ack_i && stall_i) w_next_state = S_HOLD;
        S_HOLD:  if (!stall_i)                   w_next_state = S_REQ;
        default: w_next_state = S_REQ;
      endcase
    end
  end

  // Output/control decode: bus request plus the datapath actions for this cycle.
  always_comb begin
    w_imem_req = 1'b0;
    w_capture  = 1'b0;
    w_park     = 1'b0;
    w_bubble   = 1'b0;
    w_unpark   = 1'b0;
    unique case (r_state)
      S_REQ: begin
        w_imem_req = reset;
        if (!branch_taken_i) begin
          if (imem.imem_ack_i) begin
            w_capture = !stall_i;
            w_park    = stall_i;
          end else begin
            w_bubble  = !stall_i;
          end
        end
      end
      S_HOLD: begin
        w_unpark = !branch_taken_i && !stall_i;
      end
      default: ;
    endcase
  end

  // PC and IF/ID register: reset, then redirect, then normal fetch actions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (branch_taken_i) begin
      r_pc       <= w_branch_pc;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_instr    <= imem.imem_rdata_i;
        r_pc_plus4 <= w_pc_plus4;
        r_valid    <= 1'b1;
      end else if (w_unpark) begin
        r_instr    <= r_skid_instr;
        r_pc_plus4 <= r_skid_pc_plus4;
        r_valid    <= 1'b1;
      end else if (w_bubble) begin
        r_instr    <= NOP_INSTR;
        r_valid    <= 1'b0;
      end
      if (w_capture || w_park) begin
        r_pc <= w_pc_plus4;
      end
    end
  end

  // Skid data: loaded when a stalled ack arrives.
  always_ff @(posedge clk) begin
    // NOTE: the skid payload is not reset; its occupancy lives in r_state,
    // which is reset, so stale contents are never presented.
    if (w_park) begin
      r_skid_instr    <= imem.imem_rdata_i;
      r_skid_pc_plus4 <= w_pc_plus4;
    end
  end

  assign imem.imem_req_o  = w_imem_req;
  assign imem.imem_addr_o = r_pc;

  assign instr_o    = r_instr;
  assign opcode_o   = r_instr[31:26];
  assign pc_plus4_o = r_pc_plus4;
  assign valid_o    = r_valid;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then a mixed stall/ack/branch run, all compared every cycle
// against a transaction-level model of the fetch stage.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic        ack;

  logic [31:0] instr_o;
  logic [5:0]  opcode_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: two fixed words, everything else a pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h8C08_0004;
    if (a == 32'h0040_000C) return 32'h2108_0001;
    return a ^ 32'hA5A5_0000;
  endfunction

  fetch_stage_if bus();
  assign bus.imem_ack_i   = ack;
  assign bus.imem_rdata_i = mem_word(bus.imem_addr_o);

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall),
    .branch_taken_i  (br),
    .branch_target_i (tgt),
    .imem            (bus.master),
    .instr_o         (instr_o),
    .opcode_o        (opcode_o),
    .pc_plus4_o      (pc_plus4_o),
    .valid_o         (valid_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  entry_t      skid_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  bit          m_ready = 1'b0;

  // The model advances once per edge from the inputs the DUT sees at that edge.
  always @(posedge clk) begin
    if (!reset) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_pc4 = '0; m_valid = 1'b0;
      skid_q.delete();
      m_ready = 1'b1;
    end else if (m_ready) begin
      if (br) begin
        m_pc = tgt & 32'hFFFF_FFFC;
        m_instr = NOP_INSTR; m_pc4 = '0; m_valid = 1'b0;
        skid_q.delete();
      end else if (skid_q.size() != 0) begin
        if (!stall) begin
          entry_t e;
          e = skid_q.pop_front();
          m_instr = e.instr; m_pc4 = e.pc4; m_valid = 1'b1;
        end
      end else if (ack) begin
        entry_t e;
        e.instr = mem_word(m_pc);
        e.pc4   = m_pc + 32'd4;
        if (stall) skid_q.push_back(e);
        else begin
          m_instr = e.instr; m_pc4 = e.pc4; m_valid = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end else if (!stall) begin
        m_instr = NOP_INSTR; m_valid = 1'b0;
      end
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (m_ready) begin
      check("model_req",   32'(bus.imem_req_o), 32'(reset && (skid_q.size() == 0)));
      check("model_addr",  bus.imem_addr_o, m_pc);
      check("model_valid", 32'(valid_o), 32'(m_valid));
      check("model_instr", instr_o, m_instr);
      check("model_opcode", 32'(opcode_o), 32'(m_instr[31:26]));
      if (m_valid) check("model_pc4", pc_plus4_o, m_pc4);
    end
  end

  // One cycle of stimulus: apply inputs, take an edge, settle.
  task automatic cyc(input logic s, input logic b, input logic [31:0] t, input logic a);
    stall = s; br = b; tgt = t; ack = a;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; stall = 1'b0; br = 1'b0; tgt = '0; ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   32'(bus.imem_req_o), 32'h0);
    check("rst_addr",  bus.imem_addr_o, 32'h0040_0000);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc4",   pc_plus4_o, 32'h0);

    // Reset release with ack held high.
    reset = 1'b1; #1;
    check("first_req",  32'(bus.imem_req_o), 32'h1);
    check("first_addr", bus.imem_addr_o, 32'h0040_0000);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("lw_instr",  instr_o, 32'h8C08_0004);
    check("lw_opcode", 32'(opcode_o), 32'h23);
    check("lw_pc4",    pc_plus4_o, 32'h0040_0004);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("e3_instr", instr_o, 32'hA5E5_0008);
    check("e3_pc4",   pc_plus4_o, 32'h0040_000C);
    check("e3_valid", 32'(valid_o), 32'h1);

    // Two-cycle stall coinciding with the ack of 0x2108_0001.
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    check("stall1_instr", instr_o, 32'hA5E5_0008);
    check("stall1_req",   32'(bus.imem_req_o), 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    check("stall2_instr", instr_o, 32'hA5E5_0008);
    check("stall2_req",   32'(bus.imem_req_o), 32'h0);
    check("stall2_addr",  bus.imem_addr_o, 32'h0040_0010);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("unpark_instr", instr_o, 32'h2108_0001);
    check("unpark_pc4",   pc_plus4_o, 32'h0040_0010);
    check("unpark_req",   32'(bus.imem_req_o), 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("after_instr", instr_o, 32'hA5E5_0010);
    check("after_pc4",   pc_plus4_o, 32'h0040_0014);

    // Branch in the same cycle as an ack: acked word dropped.
    cyc(1'b0, 1'b1, 32'h0040_0103, 1'b1);
    check("br_valid", 32'(valid_o), 32'h0);
    check("br_instr", instr_o, 32'h0);
    check("br_pc4",   pc_plus4_o, 32'h0);
    check("br_addr",  bus.imem_addr_o, 32'h0040_0100);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("bubble_valid", 32'(valid_o), 32'h0);
    check("bubble_addr",  bus.imem_addr_o, 32'h0040_0100);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("tgt_instr", instr_o, 32'hA5E5_0100);
    check("tgt_pc4",   pc_plus4_o, 32'h0040_0104);

    // Redirect while a word is parked in the skid.
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b1, 32'h0040_0200, 1'b1);
    check("hold_br_valid", 32'(valid_o), 32'h0);
    check("hold_br_addr",  bus.imem_addr_o, 32'h0040_0200);
    check("hold_br_req",   32'(bus.imem_req_o), 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("hold_br_drop", 32'(valid_o), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("hold_br_instr", instr_o, 32'hA5E5_0200);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    check("stall_noack_instr", instr_o, 32'hA5E5_0200);

    // Wrap at the top of the address space.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    check("wrap_addr0", bus.imem_addr_o, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_instr", instr_o, 32'h5A5A_FFFC);
    check("wrap_pc4",   pc_plus4_o, 32'h0000_0000);
    check("wrap_addr",  bus.imem_addr_o, 32'h0000_0000);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_next", instr_o, 32'hA5A5_0000);

    // Reset mid-stream with ack high.
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    reset = 1'b0; #1;
    check("mid_rst_req_low", 32'(bus.imem_req_o), 32'h0);
    @(posedge clk); #1;
    check("mid_rst_valid", 32'(valid_o), 32'h0);
    check("mid_rst_addr",  bus.imem_addr_o, 32'h0040_0000);
    check("mid_rst_req",   32'(bus.imem_req_o), 32'h0);
    reset = 1'b1;

    // Mixed traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(3) == 0, $urandom_range(15) == 0, $urandom, $urandom_range(3) != 0);
      if (i == 200) begin
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch_stage
